flash_audio_fetcher: RTL and testbench

Plays audio from flash by reading 32-bit words over an Avalon-MM read master and emitting 16-bit samples at the rate set by `sample_freq_div`. It sits downstream of the keyboard-driven playback controller and consumes its `pause`, `forward`, `fetcher_reset` and `sample_freq_div` outputs. Each word holds two samples: low half is earlier in time, high half later. Samples feed the audio output path.

---
 rtl/flash_audio_fetcher_pkg.sv | 23 ++
 rtl/flash_audio_fetcher_tick_gen.sv | 44 ++++
 rtl/flash_audio_fetcher.sv | 175 +++++++++++++++++
 tb/tb_flash_audio_fetcher.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_audio_fetcher_pkg.sv
// ---------------------------------------------------------------------------
// fetcher_pkg
//   Shared types and defaults for the flash audio fetcher and the playback
//   controller that drives it.
//   - fetch_state_t  : fetcher FSM states
//   - DEF_START_ADDR : first flash word of the default clip
//   - DEF_END_ADDR   : last flash word of the default clip (inclusive)
//   - DEF_SAMPLE_DIV : default clk cycles per sample
// ---------------------------------------------------------------------------
package fetcher_pkg;

   typedef enum logic [1:0] {
      FETCH     = 2'd0,
      WAIT_DATA = 2'd1,
      HALF1     = 2'd2,
      HALF2     = 2'd3
   } fetch_state_t;

   localparam logic [22:0] DEF_START_ADDR = 23'h0;
   localparam logic [22:0] DEF_END_ADDR   = 23'h7FFFF;
   localparam int unsigned DEF_SAMPLE_DIV = 1227;

endpackage

// File: rtl/flash_audio_fetcher_tick_gen.sv
// ---------------------------------------------------------------------------
// sample_tick_gen
//   Sample-rate divider. The counter runs 0..div-1 and holds while paused;
//   tick_o is high in the cycle the counter sits at div-1.
//   Ports:
//     clk_i    system clock
//     rst_i    synchronous active-high reset (counter -> 0)
//     div_i    clk cycles per sample; values below 2 act as 2
//     pause_i  1 = freeze counter, no ticks
//     tick_o   one-cycle sample strobe (combinational from count)
// ---------------------------------------------------------------------------
module sample_tick_gen #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] div_i,
   input  logic         pause_i,
   output logic         tick_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] div_eff;
   logic [W-1:0] last;

   always_comb begin
      div_eff = (div_i < W'(2)) ? W'(2) : div_i;
      last    = div_eff - W'(1);
      // >= rather than == so a divider that shrinks below the current count
      // ticks on the very next cycle instead of running the counter around.
      tick_o  = !pause_i && (cnt_q >= last);
      cnt_d   = cnt_q;
      if (tick_o)
         cnt_d = '0;
      else if (!pause_i)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/flash_audio_fetcher.sv
// ---------------------------------------------------------------------------
// flash_audio_fetcher
//   Streams 16-bit audio samples out of 32-bit flash words read over an
//   Avalon-MM read master. Low half of a word is the earlier sample. Plays
//   forward or backward, restarts on fetcher_reset, flags sticky underrun.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     sample_freq_div       clk cycles per sample (min 2)
//     pause                 hold playback (ticks stop, fetch continues)
//     forward               1 = forward, 0 = backward
//     fetcher_reset         one-cycle restart pulse
//     flash_address/_read   Avalon read request (registered)
//     flash_waitrequest     slave stall
//     flash_readdata/_readdatavalid  read response
//     audio_data/_valid     current sample / one-cycle new-sample strobe
//     underrun              sticky: tick arrived with no word buffered
// ---------------------------------------------------------------------------
module flash_audio_fetcher
   import fetcher_pkg::*;
#(
   parameter int                    FREQ_DIV_WIDTH = 32,
   parameter int                    ADDR_WIDTH     = 23,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR     = ADDR_WIDTH'(DEF_START_ADDR),
   parameter logic [ADDR_WIDTH-1:0] END_ADDR       = ADDR_WIDTH'(DEF_END_ADDR)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [FREQ_DIV_WIDTH-1:0] sample_freq_div,
   input  logic                      pause,
   input  logic                      forward,
   input  logic                      fetcher_reset,
   output logic [ADDR_WIDTH-1:0]     flash_address,
   output logic                      flash_read,
   input  logic                      flash_waitrequest,
   input  logic [31:0]               flash_readdata,
   input  logic                      flash_readdatavalid,
   output logic [15:0]               audio_data,
   output logic                      audio_valid,
   output logic                      underrun
);

   logic                  tick;
   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, next_addr, restart_addr;
   logic [31:0]           word_q, word_d;
   logic                  dir_q, dir_d;
   logic                  pend_q, pend_d;
   logic                  read_q, read_d;
   logic [15:0]           data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  underrun_q, underrun_d;
   logic                  accepted;
   logic                  pend_now;

   sample_tick_gen #(.W(FREQ_DIV_WIDTH)) u_tick (
      .clk_i   (clk),
      .rst_i   (rst),
      .div_i   (sample_freq_div),
      .pause_i (pause),
      .tick_o  (tick)
   );

   // A request only counts once we are actually driving it; this also keeps
   // the first post-reset cycle (read still low) from being taken as accepted.
   assign accepted     = read_q && !flash_waitrequest;
   // A restart arriving in the same cycle as the response still discards it.
   assign pend_now     = pend_q || fetcher_reset;
   assign restart_addr = forward ? START_ADDR : END_ADDR;

   always_comb begin
      if (dir_q)
         next_addr = (addr_q == END_ADDR) ? START_ADDR : addr_q + ADDR_WIDTH'(1);
      else
         next_addr = (addr_q == START_ADDR) ? END_ADDR : addr_q - ADDR_WIDTH'(1);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:     if (accepted) state_d = WAIT_DATA;
         WAIT_DATA: if (flash_readdatavalid) state_d = pend_now ? FETCH : HALF1;
         HALF1: begin
            if (fetcher_reset) state_d = FETCH;
            else if (tick)     state_d = HALF2;
         end
         HALF2:     if (fetcher_reset || tick) state_d = FETCH;
         default:   state_d = FETCH;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      addr_d     = addr_q;
      word_d     = word_q;
      dir_d      = dir_q;
      pend_d     = pend_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      underrun_d = underrun_q;
      case (state_q)
         FETCH, WAIT_DATA: begin
            if (tick)          underrun_d = 1'b1;
            // The in-flight read must complete, so the restart is deferred
            // until its response has been swallowed.
            if (fetcher_reset) pend_d     = 1'b1;
            if (state_q == WAIT_DATA && flash_readdatavalid) begin
               if (pend_now) begin
                  addr_d = restart_addr;
                  pend_d = 1'b0;
               end else begin
                  word_d = flash_readdata;
                  dir_d  = forward;
               end
            end
         end
         HALF1: begin
            if (fetcher_reset) begin
               addr_d = restart_addr;
            end else if (tick) begin
               data_d  = dir_q ? word_q[15:0] : word_q[31:16];
               valid_d = 1'b1;
            end
         end
         HALF2: begin
            if (fetcher_reset) begin
               addr_d = restart_addr;
            end else if (tick) begin
               data_d  = dir_q ? word_q[31:16] : word_q[15:0];
               valid_d = 1'b1;
               addr_d  = next_addr;
            end
         end
         default: ;
      endcase
      // Registered request follows the state we are entering, so the read
      // drops on the same edge that leaves FETCH.
      read_d = (state_d == FETCH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q     <= START_ADDR;
         word_q     <= '0;
         dir_q      <= 1'b1;
         pend_q     <= 1'b0;
         read_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         word_q     <= word_d;
         dir_q      <= dir_d;
         pend_q     <= pend_d;
         read_q     <= read_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         underrun_q <= underrun_d;
      end
   end

   assign flash_address = addr_q;
   assign flash_read    = read_q;
   assign audio_data    = data_q;
   assign audio_valid   = valid_q;
   assign underrun      = underrun_q;

endmodule

// File: tb/tb_flash_audio_fetcher.sv
// ---------------------------------------------------------------------------
// tb_flash_audio_fetcher
//   Directed bench for flash_audio_fetcher with a one-outstanding-read flash
//   model (configurable latency and stall window). Word at address a is
//   32'hBBBB_AAAA for a=0, else {a[15:0]^16'hF0F0, a[15:0]}.
// ---------------------------------------------------------------------------
module tb_flash_audio_fetcher;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] sample_freq_div;
   logic        pause;
   logic        forward;
   logic        fetcher_reset;
   logic [22:0] flash_address;
   logic        flash_read;
   logic        flash_waitrequest   = 1'b0;
   logic [31:0] flash_readdata      = 32'h0;
   logic        flash_readdatavalid = 1'b0;
   logic [15:0] audio_data;
   logic        audio_valid;
   logic        underrun;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int stall_until = 0;
   int lat_cfg = 2;
   int lat_cnt = 0;
   int vcount = 0;
   int v0;
   logic [22:0] pend_addr = 23'h0;

   flash_audio_fetcher dut (
      .clk                 (clk),
      .rst                 (rst),
      .sample_freq_div     (sample_freq_div),
      .pause               (pause),
      .forward             (forward),
      .fetcher_reset       (fetcher_reset),
      .flash_address       (flash_address),
      .flash_read          (flash_read),
      .flash_waitrequest   (flash_waitrequest),
      .flash_readdata      (flash_readdata),
      .flash_readdatavalid (flash_readdatavalid),
      .audio_data          (audio_data),
      .audio_valid         (audio_valid),
      .underrun            (underrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [22:0] a);
      if (a == 23'd0) return 32'hBBBB_AAAA;
      return {a[15:0] ^ 16'hF0F0, a[15:0]};
   endfunction

   // Flash slave: drives mid-cycle, accepts on read && !waitrequest,
   // responds lat_cfg cycles after the accepting cycle.
   always @(negedge clk) begin
      flash_readdatavalid = 1'b0;
      if (rst) begin
         lat_cnt = 0;
      end else if (lat_cnt > 0) begin
         lat_cnt = lat_cnt - 1;
         if (lat_cnt == 0) begin
            flash_readdatavalid = 1'b1;
            flash_readdata      = mem_word(pend_addr);
         end
      end
      flash_waitrequest = (cyc < stall_until);
      if (!rst && flash_read === 1'b1 && !flash_waitrequest) begin
         pend_addr = flash_address;
         lat_cnt   = lat_cfg;
      end
   end

   always @(negedge clk) if (audio_valid === 1'b1) vcount++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_read"},     32'(flash_read),    32'h0);
      chk({tag, "_addr"},     32'(flash_address), 32'h0);
      chk({tag, "_data"},     32'(audio_data),    32'h0);
      chk({tag, "_valid"},    32'(audio_valid),   32'h0);
      chk({tag, "_underrun"}, 32'(underrun),      32'h0);
   endtask

   initial begin
      rst = 1'b1; pause = 1'b1; forward = 1'b1; fetcher_reset = 1'b0;
      sample_freq_div = 32'd4;
      step(3);
      chk_reset_vals("rst0");

      // Forward play, div=4, latency 2: let the first word load while paused
      rst = 1'b0;
      step(10);
      chk("fwd_idle_read", 32'(flash_read), 32'h0);
      chk("fwd_no_underrun0", 32'(underrun), 32'h0);
      chk("fwd_no_valid_paused", 32'(vcount), 32'h0);
      pause = 1'b0;
      step(3);  chk("fwd_pre_tick", 32'(audio_valid), 32'h0);
      step(1);  chk("fwd_s0_valid", 32'(audio_valid), 32'h1);
                chk("fwd_s0_data", 32'(audio_data), 32'hAAAA);
      step(1);  chk("fwd_valid_pulse", 32'(audio_valid), 32'h0);
      step(3);  chk("fwd_s1_valid", 32'(audio_valid), 32'h1);
                chk("fwd_s1_data", 32'(audio_data), 32'hBBBB);
                chk("fwd_next_addr", 32'(flash_address), 32'h1);
                chk("fwd_next_read", 32'(flash_read), 32'h1);
      step(4);  chk("fwd_s2_data", 32'(audio_data), 32'h0001);
                chk("fwd_s2_valid", 32'(audio_valid), 32'h1);
      step(4);  chk("fwd_s3_data", 32'(audio_data), 32'hF0F1);
                chk("fwd_addr2", 32'(flash_address), 32'h2);
                chk("fwd_no_underrun", 32'(underrun), 32'h0);

      // Pause during HALF1 with count at 2 of 0..3
      step(2);  pause = 1'b1; v0 = vcount;
      step(50); chk("pause_no_valid", 32'(vcount), 32'(v0));
      pause = 1'b0;
      step(1);  chk("pause_resume_wait", 32'(audio_valid), 32'h0);
      step(1);  chk("pause_resume_valid", 32'(audio_valid), 32'h1);
                chk("pause_resume_data", 32'(audio_data), 32'h0002);
      step(4);  chk("pause_s_hi", 32'(audio_data), 32'hF0F2);
                chk("pause_addr3", 32'(flash_address), 32'h3);
      step(4);  chk("pre_bwd_data", 32'(audio_data), 32'h0003);

      // Backward restart from HALF2: word at END played high then low
      pause = 1'b1; forward = 1'b0; fetcher_reset = 1'b1;
      step(1);  fetcher_reset = 1'b0;
                chk("bwd_addr_end", 32'(flash_address), 32'h7FFFF);
                chk("bwd_read", 32'(flash_read), 32'h1);
                chk("bwd_not_played", 32'(audio_valid), 32'h0);
      step(11); pause = 1'b0;
      step(4);  chk("bwd_s0_hi", 32'(audio_data), 32'h0F0F);
                chk("bwd_s0_valid", 32'(audio_valid), 32'h1);
      step(4);  chk("bwd_s1_lo", 32'(audio_data), 32'hFFFF);
                chk("bwd_addr_dec", 32'(flash_address), 32'h7FFFE);
      step(4);  chk("bwd_s2_hi", 32'(audio_data), 32'h0F0E);
      step(4);  chk("bwd_s3_lo", 32'(audio_data), 32'hFFFE);
                chk("bwd_addr_dec2", 32'(flash_address), 32'h7FFFD);

      // Restart while a read is in flight: response discarded, refetch END,
      // then play it forward so the next address wraps to START
      pause = 1'b1; fetcher_reset = 1'b1;
      step(1);  fetcher_reset = 1'b0;
                chk("pend_wait_read", 32'(flash_read), 32'h0);
      step(2);  chk("pend_restart_addr", 32'(flash_address), 32'h7FFFF);
                chk("pend_restart_read", 32'(flash_read), 32'h1);
      forward = 1'b1;
      step(6);  pause = 1'b0;
      step(4);  chk("wrap_s0_lo", 32'(audio_data), 32'hFFFF);
      step(4);  chk("wrap_s1_hi", 32'(audio_data), 32'h0F0F);
                chk("wrap_addr_start", 32'(flash_address), 32'h0);
                chk("wrap_no_underrun", 32'(underrun), 32'h0);

      // Restart during a 10-cycle stall: request held, response discarded
      pause = 1'b1; stall_until = cyc + 10;
      step(2);  fetcher_reset = 1'b1;
      step(1);  fetcher_reset = 1'b0;
      step(4);  chk("stall_read_held", 32'(flash_read), 32'h1);
                chk("stall_addr_held", 32'(flash_address), 32'h0);
      step(6);  chk("stall_refetch_read", 32'(flash_read), 32'h1);
                chk("stall_refetch_addr", 32'(flash_address), 32'h0);
      step(4);  pause = 1'b0;
      step(4);  chk("stall_s0", 32'(audio_data), 32'hAAAA);
                chk("stall_s0_valid", 32'(audio_valid), 32'h1);
      step(4);  chk("stall_s1", 32'(audio_data), 32'hBBBB);
                chk("stall_addr1", 32'(flash_address), 32'h1);

      // Underrun: div=2, latency 8
      lat_cfg = 8; sample_freq_div = 32'd2;
      step(2);  chk("urun_set", 32'(underrun), 32'h1);
                chk("urun_no_valid", 32'(audio_valid), 32'h0);
                chk("urun_data_held", 32'(audio_data), 32'hBBBB);
      step(2);  chk("urun_no_valid2", 32'(audio_valid), 32'h0);
                chk("urun_sticky", 32'(underrun), 32'h1);
      rst = 1'b1; pause = 1'b1; lat_cfg = 2; sample_freq_div = 32'd0;
      step(2);
      chk_reset_vals("rst1");

      // Divider clamp: div=0 then div=1 both tick every 2 cycles
      rst = 1'b0;
      step(6);  pause = 1'b0;
      step(2);  chk("div0_s0", 32'(audio_data), 32'hAAAA);
                chk("div0_s0_valid", 32'(audio_valid), 32'h1);
      step(1);  chk("div0_gap", 32'(audio_valid), 32'h0);
      step(1);  chk("div0_s1", 32'(audio_data), 32'hBBBB);
                chk("div0_s1_valid", 32'(audio_valid), 32'h1);
      pause = 1'b1; sample_freq_div = 32'd1;
      step(4);  pause = 1'b0;
      step(2);  chk("div1_s0", 32'(audio_data), 32'h0001);
                chk("div1_no_underrun", 32'(underrun), 32'h0);
      step(1);  chk("div1_gap", 32'(audio_valid), 32'h0);
      step(1);  chk("div1_s1", 32'(audio_data), 32'hF0F1);
                chk("div1_s1_valid", 32'(audio_valid), 32'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
